// File: rtl/kl_pkg.sv
// Shared operand shapes, frame geometry and FSM states for the operand packer.
package kl_pkg;
  typedef logic [1:0][3:1][3:2]      otcfcybf_t;
  typedef logic [2:3][1:2][3:0][2:3] souaft_t;

  localparam int FRAME_BYTES = 6;
  localparam int RSVD_LSB    = 44;
  localparam int ASM_W       = 8 * FRAME_BYTES;

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT} state_t;
endpackage

// File: rtl/kl_idle_timer.sv
// Saturating idle counter; expired flags the run cycle on which the count reaches MAX.
// MAX of 0 never expires.
module kl_idle_timer #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int unsigned W   = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam int unsigned LIM = (MAX > 0) ? MAX - 1 : 0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (MAX != 0) && run && (cnt == W'(LIM));
endmodule

// File: rtl/kl_operand_packer.sv
// Packs 6-byte frames into otcfcybf/souaft operands; result appears one cycle after the last byte.
// A completed frame waits in the assembly register (in_ready low) while the output register is full.
module kl_operand_packer
  import kl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int          CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0][3:1][3:2]      out_otcfcybf,
  output logic [2:3][1:2][3:0][2:3] out_souaft,
  output logic                      out_xz,
  output logic                      err_short,
  output logic                      err_timeout,
  output logic                      err_rsvd,
  output logic [CNT_W-1:0]          frame_cnt
);
  state_t           state, state_nxt;
  logic [2:0]       count, count_nxt;
  logic [ASM_W-1:0] asm_q, asm_now;
  logic             xz_q, xz_now;
  otcfcybf_t        otc_now;
  souaft_t          sou_now;
  logic             accept, out_free, load_out;
  logic             tmr_run, tmr_exp;
  logic             short_nxt, tmo_nxt, rsvd_nxt;

  assign in_ready = (state != WAIT) && rst_n;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign tmr_run  = (state == COLLECT) && !accept;

  kl_idle_timer #(.MAX(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!tmr_run),
    .run     (tmr_run),
    .expired (tmr_exp)
  );

  // Frame as it stands after this cycle's byte, so completion can bypass straight to the output.
  always_comb begin
    asm_now = asm_q;
    if (accept) asm_now[{count, 3'b000} +: 8] = in_data;
    xz_now  = ((state == IDLE) ? 1'b0 : xz_q) | (accept && $isunknown(^in_data));
    otc_now = asm_now[11:0];
    sou_now = asm_now[RSVD_LSB-1:12];
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load_out  = 1'b0;
    short_nxt = 1'b0;
    tmo_nxt   = 1'b0;
    rsvd_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            short_nxt = 1'b1;
          end else begin
            state_nxt = COLLECT;
            count_nxt = 3'd1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count == 3'(FRAME_BYTES - 1)) begin
            rsvd_nxt  = |asm_now[ASM_W-1:RSVD_LSB];
            count_nxt = 3'd0;
            if (out_free) begin
              load_out  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = WAIT;
            end
          end else if (in_last) begin
            short_nxt = 1'b1;
            count_nxt = 3'd0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + 3'd1;
          end
        end else if (tmr_exp) begin
          tmo_nxt   = 1'b1;
          count_nxt = 3'd0;
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (out_free) begin
          load_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      asm_q        <= '0;
      xz_q         <= 1'b0;
      out_valid    <= 1'b0;
      out_otcfcybf <= '0;
      out_souaft   <= '0;
      out_xz       <= 1'b0;
      err_short    <= 1'b0;
      err_timeout  <= 1'b0;
      err_rsvd     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      xz_q        <= xz_now;
      err_short   <= short_nxt;
      err_timeout <= tmo_nxt;
      err_rsvd    <= rsvd_nxt;
      if (accept) asm_q <= asm_now;
      if (load_out) begin
        out_valid    <= 1'b1;
        out_otcfcybf <= otc_now;
        out_souaft   <= sou_now;
        out_xz       <= xz_now;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_kl_operand_packer.sv
// Bench for kl_operand_packer: directed scenarios plus a randomized run against a queue model.
module tb_kl_operand_packer;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_xz, err_short, err_timeout, err_rsvd;
  logic [11:0] otc;
  logic [31:0] sou;
  logic [2:0]  frame_cnt;
  logic        nt_in_ready, nt_out_valid, nt_out_xz, nt_err_short, nt_err_timeout, nt_err_rsvd;
  logic [11:0] nt_otc;
  logic [31:0] nt_sou;
  logic [15:0] nt_frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  kl_operand_packer #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_otcfcybf(otc),
    .out_souaft(sou), .out_xz(out_xz), .err_short(err_short), .err_timeout(err_timeout),
    .err_rsvd(err_rsvd), .frame_cnt(frame_cnt)
  );

  kl_operand_packer #(.TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nt_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(nt_out_valid), .out_ready(out_ready), .out_otcfcybf(nt_otc),
    .out_souaft(nt_sou), .out_xz(nt_out_xz), .err_short(nt_err_short), .err_timeout(nt_err_timeout),
    .err_rsvd(nt_err_rsvd), .frame_cnt(nt_frame_cnt)
  );

  function automatic logic [47:0] seq48(input logic [7:0] base);
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[8*i +: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic send_seq(input logic [7:0] base);
    for (int i = 0; i < 6; i++) drive(1'b1, base + 8'(i), i == 5);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (otc !== 12'h0 || sou !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", otc, sou); end
    n_cmp++; if ({out_xz, err_short, err_timeout, err_rsvd} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {out_xz, err_short, err_timeout, err_rsvd}); end
    n_cmp++; if (frame_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(i + 1), i == 5);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (otc !== 12'h201) begin n_err++; $display("FAIL basic_otc: got %h want 201", otc); end
    n_cmp++; if (sou !== 32'h60504030) begin n_err++; $display("FAIL basic_sou: got %h want 60504030", sou); end
    exp_cnt++;
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    n_cmp++; if (frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL basic_cnt: got %0d want %0d", frame_cnt, 3'(exp_cnt)); end
  endtask

  task automatic test_back_to_back;
    logic [47:0] a, b;
    a = seq48(8'h10);
    b = seq48(8'h20);
    out_ready = 1'b0;
    send_seq(8'h10);
    send_seq(8'h20);
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got in_ready %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || otc !== a[11:0] || sou !== a[43:12]) begin n_err++; $display("FAIL b2b_first_held: got %b %h %h want 1 %h %h", out_valid, otc, sou, a[11:0], a[43:12]); end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (otc !== a[11:0] || sou !== a[43:12] || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stable: got %h %h rdy %b", otc, sou, in_ready); end
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    exp_cnt++;
    n_cmp++; if (out_valid !== 1'b1 || otc !== b[11:0] || sou !== b[43:12]) begin n_err++; $display("FAIL b2b_second: got %b %h %h want 1 %h %h", out_valid, otc, sou, b[11:0], b[43:12]); end
    n_cmp++; if (in_ready !== 1'b1 || frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL b2b_release: got rdy %b cnt %0d want 1 %0d", in_ready, frame_cnt, 3'(exp_cnt)); end
    drive(1'b0, 8'h00, 1'b0);
    exp_cnt++;
    n_cmp++; if (out_valid !== 1'b0 || frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL b2b_done: got %b cnt %0d want 0 %0d", out_valid, frame_cnt, 3'(exp_cnt)); end
  endtask

  task automatic test_short;
    logic [47:0] e;
    e = seq48(8'hB0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), i == 3);
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_short !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL short_pulse: got short %b valid %b want 1 0", err_short, out_valid); end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_short !== 1'b0) begin n_err++; $display("FAIL short_one_cycle: got %b want 0", err_short); end
    send_seq(8'hB0);
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || otc !== e[11:0] || sou !== e[43:12]) begin n_err++; $display("FAIL short_next_frame: got %b %h %h want 1 %h %h", out_valid, otc, sou, e[11:0], e[43:12]); end
    exp_cnt++;
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_timeout;
    logic [47:0] e;
    e = seq48(8'hD0);
    out_ready = 1'b1;
    drive(1'b1, 8'hC0, 1'b0);
    drive(1'b1, 8'hC1, 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b want 0", err_timeout); end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_pulse: got %b want 1", err_timeout); end
    n_cmp++; if (nt_err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_disabled: got %b want 0", nt_err_timeout); end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_one_cycle: got %b want 0", err_timeout); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'hD0 + 8'(i), i == 5);
      if (i == 4) begin
        n_cmp++; if (nt_out_valid !== 1'b1 || nt_otc !== 12'h1C0 || nt_sou !== 32'h3D2D1D0C) begin n_err++; $display("FAIL timeout_disabled_frame: got %b %h %h want 1 1c0 3d2d1d0c", nt_out_valid, nt_otc, nt_sou); end
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || otc !== e[11:0] || sou !== e[43:12]) begin n_err++; $display("FAIL timeout_next_frame: got %b %h %h want 1 %h %h", out_valid, otc, sou, e[11:0], e[43:12]); end
    exp_cnt++;
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_rsvd_xz;
    logic [7:0]  b [6];
    logic [47:0] e;
    logic        xz_exp;
    b = '{8'hE0, 8'hE1, 8'b1x00_0000, 8'hE3, 8'hE4, 8'hF0};
    for (int i = 0; i < 6; i++) e[8*i +: 8] = b[i];
    xz_exp = $isunknown(b[2]);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, b[i], i == 5);
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_rsvd !== 1'b1) begin n_err++; $display("FAIL rsvd_pulse: got %b want 1", err_rsvd); end
    n_cmp++; if (out_valid !== 1'b1 || otc !== e[11:0] || sou !== e[43:12]) begin n_err++; $display("FAIL rsvd_delivered: got %b %h %h want 1 %h %h", out_valid, otc, sou, e[11:0], e[43:12]); end
    n_cmp++; if (out_xz !== xz_exp) begin n_err++; $display("FAIL xz_flag: got %b want %b", out_xz, xz_exp); end
    exp_cnt++;
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_rsvd !== 1'b0) begin n_err++; $display("FAIL rsvd_one_cycle: got %b want 0", err_rsvd); end
  endtask

  task automatic test_reset_mid;
    logic [47:0] e;
    e = seq48(8'h60);
    out_ready = 1'b0;
    send_seq(8'h40);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h50 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_cmp++; if (out_valid !== 1'b0 || otc !== 12'h0 || sou !== 32'h0) begin n_err++; $display("FAIL midreset_out: got %b %h %h want 0 0 0", out_valid, otc, sou); end
    n_cmp++; if (in_ready !== 1'b0 || frame_cnt !== 3'd0 || {err_short, err_timeout, err_rsvd} !== 3'b0) begin n_err++; $display("FAIL midreset_ctl: got rdy %b cnt %0d err %b", in_ready, frame_cnt, {err_short, err_timeout, err_rsvd}); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_seq(8'h60);
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || otc !== e[11:0] || sou !== e[43:12] || out_xz !== 1'b0) begin n_err++; $display("FAIL midreset_fresh: got %b %h %h xz %b want 1 %h %h 0", out_valid, otc, sou, out_xz, e[11:0], e[43:12]); end
    exp_cnt++;
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL midreset_cnt: got %0d want %0d", frame_cnt, 3'(exp_cnt)); end
  endtask

  task automatic test_wrap;
    logic        stall;
    logic [47:0] e;
    stall = 1'b0;
    e = seq48(8'h70);
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1'b1, 8'(f * 16 + i), i == 5);
        if (in_ready !== 1'b1) stall = 1'b1;
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    exp_cnt += 7;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL wrap_bubble: got stall %b want 0", stall); end
    n_cmp++; if (out_valid !== 1'b1 || otc !== e[11:0] || sou !== e[43:12]) begin n_err++; $display("FAIL wrap_last: got %b %h %h want 1 %h %h", out_valid, otc, sou, e[11:0], e[43:12]); end
    n_cmp++; if (frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL wrap_zero: got %0d want %0d", frame_cnt, 3'(exp_cnt)); end
    exp_cnt++;
    drive(1'b0, 8'h00, 1'b0);
    n_cmp++; if (frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL wrap_after: got %0d want %0d", frame_cnt, 3'(exp_cnt)); end
  endtask

  task automatic test_random(input int cycles);
    logic [47:0] qd [$];
    logic        qx [$];
    logic [47:0] cur;
    logic        cur_xz, e_short, e_to, e_rsvd, ihs, ohs;
    int          k, idle;
    cur = '0; cur_xz = 1'b0; e_short = 1'b0; e_to = 1'b0; e_rsvd = 1'b0; k = 0; idle = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_cmp++; if ({err_short, err_timeout, err_rsvd} !== {e_short, e_to, e_rsvd}) begin n_err++; $display("FAIL rnd_err c%0d: got %b want %b", c, {err_short, err_timeout, err_rsvd}, {e_short, e_to, e_rsvd}); end
      n_cmp++; if (out_valid !== (qd.size() > 0) || in_ready !== (qd.size() < 2)) begin n_err++; $display("FAIL rnd_flow c%0d: got vld %b rdy %b want %b %b", c, out_valid, in_ready, qd.size() > 0, qd.size() < 2); end
      n_cmp++; if (frame_cnt !== 3'(exp_cnt)) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, frame_cnt, 3'(exp_cnt)); end
      if (qd.size() > 0) begin
        n_cmp++; if (otc !== qd[0][11:0] || sou !== qd[0][43:12] || out_xz !== qx[0]) begin n_err++; $display("FAIL rnd_data c%0d: got %h %h %b want %h %h %b", c, otc, sou, out_xz, qd[0][11:0], qd[0][43:12], qx[0]); end
      end
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      in_last   = (k == 5) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      e_short = 1'b0; e_to = 1'b0; e_rsvd = 1'b0;
      ihs = in_valid && (qd.size() < 2);
      ohs = (qd.size() > 0) && out_ready;
      if (ohs) begin
        void'(qd.pop_front());
        void'(qx.pop_front());
        exp_cnt++;
      end
      if (ihs) begin
        cur[8*k +: 8] = in_data;
        cur_xz = ((k == 0) ? 1'b0 : cur_xz) | $isunknown(in_data);
        idle = 0;
        if (k == 5) begin
          qd.push_back(cur);
          qx.push_back(cur_xz);
          e_rsvd = |in_data[7:4];
          k = 0;
        end else if (in_last) begin
          e_short = 1'b1;
          k = 0;
        end else begin
          k++;
        end
      end else if (k > 0) begin
        idle++;
        if (idle == TMO) begin
          e_to = 1'b1;
          k = 0;
          idle = 0;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_short;
    test_timeout;
    test_rsvd_xz;
    test_reset_mid;
    test_wrap;
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
